fifo_flagged: RTL

- Single-clock, parametrised first-word-fall-through FIFO.
- Successor to the team's basic byte FIFO, which buffered both strobes and moved pointers on the opposite clock edge.
- Adds all-entries-usable depth, occupancy count, programmable almost-full/almost-empty flags, selectable overflow policy (drop-new or overwrite-oldest), synchronous flush, and sticky overflow/underflow flags.
- Used between peripherals (UART, SPI, video) and the Wishbone register interface.

---
 rtl/fifo_flagged.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_flagged.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty flags, drop-or-overwrite policy, flush and sticky error flags.
module fifo_flagged #(
  parameter int WORD_SIZE          = 8,
  parameter int ADDRESS_SIZE       = 4,
  parameter int ALMOST_FULL_LEVEL  = 12,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter int OVERWRITE_ON_FULL  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [WORD_SIZE-1:0]    dataIn,
  input  logic                    we,
  input  logic                    oe,
  input  logic                    clearFlags,
  output logic [WORD_SIZE-1:0]    dataOut,
  output logic                    isData,
  output logic                    bufferFull,
  output logic                    almostFull,
  output logic                    almostEmpty,
  output logic [ADDRESS_SIZE:0]   count,
  output logic                    dataLost,
  output logic                    underflow
);

  localparam int DEPTH = 1 << ADDRESS_SIZE;
  localparam logic [ADDRESS_SIZE:0] depthCount  = {1'b1, {ADDRESS_SIZE{1'b0}}};
  localparam logic [ADDRESS_SIZE:0] afLevel     = ALMOST_FULL_LEVEL[ADDRESS_SIZE:0];
  localparam logic [ADDRESS_SIZE:0] aeLevel     = ALMOST_EMPTY_LEVEL[ADDRESS_SIZE:0];
  localparam logic                  overwriteEn = (OVERWRITE_ON_FULL != 0);

  logic [WORD_SIZE-1:0]    mem [DEPTH];
  logic [ADDRESS_SIZE-1:0] readPointer;
  logic [ADDRESS_SIZE-1:0] writePointer;
  logic [ADDRESS_SIZE:0]   countReg;
  logic [ADDRESS_SIZE:0]   countNext;
  logic                    dataLostReg;
  logic                    underflowReg;

  logic isEmpty;
  logic isFull;
  logic doWrite;
  logic doRead;
  logic lostEvent;
  logic underEvent;

  assign isEmpty = (countReg == {(ADDRESS_SIZE+1){1'b0}});
  assign isFull  = (countReg == depthCount);

  // Decide which strobes take effect; full/empty come from the count, not pointer equality.
  always_comb begin
    doWrite    = 1'b0;
    doRead     = 1'b0;
    lostEvent  = 1'b0;
    underEvent = 1'b0;
    if (isEmpty) begin
      doWrite    = we;
      underEvent = oe;
    end else if (isFull) begin
      if (we && !oe) begin
        // Overwrite mode writes into the oldest slot and drags the read pointer along.
        lostEvent = 1'b1;
        doWrite   = overwriteEn;
        doRead    = overwriteEn;
      end else begin
        doWrite = we;
        doRead  = oe;
      end
    end else begin
      doWrite = we;
      doRead  = oe;
    end
  end

  // Occupancy update from the accepted strobes.
  always_comb begin
    case ({doWrite, doRead})
      2'b10:   countNext = countReg + (ADDRESS_SIZE+1)'(1);
      2'b01:   countNext = countReg - (ADDRESS_SIZE+1)'(1);
      default: countNext = countReg;
    endcase
  end

  // Pointer, count and sticky flag registers; rst outranks flush outranks normal traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      readPointer  <= {ADDRESS_SIZE{1'b0}};
      writePointer <= {ADDRESS_SIZE{1'b0}};
      countReg     <= {(ADDRESS_SIZE+1){1'b0}};
      dataLostReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      if (doWrite) writePointer <= writePointer + ADDRESS_SIZE'(1);
      if (doRead)  readPointer  <= readPointer + ADDRESS_SIZE'(1);
      countReg     <= countNext;
      dataLostReg  <= lostEvent  | (dataLostReg  & ~clearFlags);
      underflowReg <= underEvent | (underflowReg & ~clearFlags);
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && doWrite) mem[writePointer] <= dataIn;
  end

  assign dataOut     = isEmpty ? {WORD_SIZE{1'b0}} : mem[readPointer];
  assign isData      = !isEmpty;
  assign bufferFull  = isFull;
  assign almostFull  = (countReg >= afLevel);
  assign almostEmpty = (countReg <= aeLevel);
  assign count       = countReg;
  assign dataLost    = dataLostReg;
  assign underflow   = underflowReg;

endmodule
